reg_bank_mp: RTL and testbench

Parametrised multi-port general-purpose register bank. It succeeds the fixed 32x32, 2-read/1-write bank used by the MIPS datapath and generalises width, depth and port count. It adds byte-enabled writes, deterministic write-write conflict resolution, optional same-cycle write-to-read bypass and a hardwired zero register. It sits in the decode stage, feeding the ALU operand muxes, and takes writeback from the WB stage.

---
 rtl/reg_bank_pkg.sv | 15 +
 rtl/reg_bank_merge.sv | 31 +++
 rtl/reg_bank_mp.sv | 146 ++++++++++++++
 tb/tb_reg_bank_mp.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/reg_bank_pkg.sv
// Shared constants for the multi-port register bank: default geometry,
// byte-lane width and the hardwired zero-register index.
package reg_bank_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;
    localparam int BE_W       = DEF_DATA_W / 8;
    localparam int ZERO_IDX   = 0;

    // Number of byte lanes for an arbitrary register width.
    function automatic int beWidth(input int dataW);
        return dataW / 8;
    endfunction

endpackage

// File: rtl/reg_bank_merge.sv
// Combinational byte-lane merge of an old register value with up to NUM_WR
// byte-enabled writes. Higher-numbered ports win every lane they enable.
module reg_bank_merge
    import reg_bank_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int NUM_WR = 1
) (
    input  logic [DATA_W-1:0]              oldVal,
    input  logic [NUM_WR-1:0]              wrHit,
    input  logic [NUM_WR*DATA_W-1:0]       wrData,
    input  logic [NUM_WR*(DATA_W/8)-1:0]   wrBe,
    output logic [DATA_W-1:0]              newVal
);

    localparam int BeW = beWidth(DATA_W);

    // Walk ports in ascending order so the last enabled port owns each lane.
    always_comb begin
        // NOTE: assign every combinational output a default first; a path that skips the assignment infers a latch.
        newVal = oldVal;
        for (int w = 0; w < NUM_WR; w++) begin
            for (int b = 0; b < BeW; b++) begin
                if (wrHit[w] && wrBe[w*BeW + b]) begin
                    newVal[b*8 +: 8] = wrData[w*DATA_W + b*8 +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/reg_bank_mp.sv
// Parametrised multi-port register bank with byte-enabled writes, per-lane
// write-conflict priority, optional same-cycle bypass and a zero register.
// Optional busy scoreboard enabled by defining REG_BANK_SCOREBOARD_EN.
module reg_bank_mp
    import reg_bank_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int NUM_RD   = 2,
    parameter int NUM_WR   = 1,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_RD*ADDR_W-1:0]       rd_addr,
    output logic [NUM_RD*DATA_W-1:0]       rd_data,
    input  logic [NUM_WR-1:0]              wr_en,
    input  logic [NUM_WR*ADDR_W-1:0]       wr_addr,
    input  logic [NUM_WR*DATA_W-1:0]       wr_data,
    input  logic [NUM_WR*(DATA_W/8)-1:0]   wr_be,
    input  logic                           sb_set,
    input  logic [ADDR_W-1:0]              sb_addr,
    output logic [NUM_RD-1:0]              rd_busy
);

    localparam int DEPTH = 2**ADDR_W;
    localparam int BeW   = beWidth(DATA_W);

    logic [DATA_W-1:0] regs     [DEPTH];
    logic [DATA_W-1:0] nextVals [DEPTH];

    // ---------------- write path: one lane-merge per register ----------------
    for (genvar r = 0; r < DEPTH; r++) begin : g_reg
        logic [NUM_WR-1:0] hit;

        // A port hits this register when enabled and addressed; register 0 is never written.
        always_comb begin
            hit = '0;
            for (int w = 0; w < NUM_WR; w++) begin
                hit[w] = wr_en[w] && (wr_addr[w*ADDR_W +: ADDR_W] == ADDR_W'(r))
                         && !(ZERO_REG != 0 && r == ZERO_IDX);
            end
        end

        reg_bank_merge #(.DATA_W(DATA_W), .NUM_WR(NUM_WR)) u_merge (
            .oldVal (regs[r]),
            .wrHit  (hit),
            .wrData (wr_data),
            .wrBe   (wr_be),
            .newVal (nextVals[r])
        );
    end

    // Register array update; the whole flop array is cleared by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: this is a flop array, not a RAM, so every entry gets an explicit reset value.
            for (int r = 0; r < DEPTH; r++) regs[r] <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so all flops sample pre-edge values.
            for (int r = 0; r < DEPTH; r++) regs[r] <= nextVals[r];
        end
    end

`ifdef REG_BANK_SCOREBOARD_EN
    logic [DEPTH-1:0] busy;
    logic [DEPTH-1:0] busyNext;

    // A write enabling any byte clears busy; a same-cycle set on the same address wins.
    always_comb begin
        busyNext = busy;
        for (int r = 0; r < DEPTH; r++) begin
            for (int w = 0; w < NUM_WR; w++) begin
                if (wr_en[w] && (wr_addr[w*ADDR_W +: ADDR_W] == ADDR_W'(r))
                    && (|wr_be[w*BeW +: BeW])) begin
                    busyNext[r] = 1'b0;
                end
            end
            if (sb_set && (sb_addr == ADDR_W'(r)) && !(ZERO_REG != 0 && r == ZERO_IDX)) begin
                busyNext[r] = 1'b1;
            end
        end
    end

    // Busy-bit storage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) busy <= '0;
        else     busy <= busyNext;
    end
`else
    logic unusedSb;
    assign unusedSb = ^{sb_set, sb_addr};
    assign rd_busy  = '0;
`endif

    // ---------------- read path: one bypass merge per read port -------------
    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic [NUM_WR-1:0] hit;
        logic [DATA_W-1:0] fwdVal;
        logic [DATA_W-1:0] rdVal;

        assign ra = rd_addr[i*ADDR_W +: ADDR_W];

        // Active writes targeting this read address this cycle.
        always_comb begin
            hit = '0;
            for (int w = 0; w < NUM_WR; w++) begin
                hit[w] = wr_en[w] && (wr_addr[w*ADDR_W +: ADDR_W] == ra);
            end
        end

        reg_bank_merge #(.DATA_W(DATA_W), .NUM_WR(NUM_WR)) u_fwd (
            .oldVal (regs[ra]),
            .wrHit  (hit),
            .wrData (wr_data),
            .wrBe   (wr_be),
            .newVal (fwdVal)
        );

        // Zero register masks everything, including forwarded data.
        always_comb begin
            if (ZERO_REG != 0 && ra == ADDR_W'(ZERO_IDX)) rdVal = '0;
            else if (BYPASS != 0)                         rdVal = fwdVal;
            else                                          rdVal = regs[ra];
        end

        assign rd_data[i*DATA_W +: DATA_W] = rdVal;

`ifdef REG_BANK_SCOREBOARD_EN
        logic clrNow;

        // A byte-enabled write to this address is clearing its busy bit this cycle.
        always_comb begin
            clrNow = 1'b0;
            for (int w = 0; w < NUM_WR; w++) begin
                if (hit[w] && (|wr_be[w*BeW +: BeW])) clrNow = 1'b1;
            end
        end

        assign rd_busy[i] = (BYPASS != 0 && clrNow) ? 1'b0 : busy[ra];
`endif
    end

endmodule

// File: tb/tb_reg_bank_mp.sv
// Directed, table-driven bench for reg_bank_mp with two write ports.
// A second instance with BYPASS=0 shares the stimulus to show the old value.
module tb_reg_bank_mp;

    logic        clk;
    logic        rst;
    logic [9:0]  rd_addr;
    logic [63:0] rd_data;
    logic [63:0] rdDataNb;
    logic [1:0]  wr_en;
    logic [9:0]  wr_addr;
    logic [63:0] wr_data;
    logic [7:0]  wr_be;
    logic        sb_set;
    logic [4:0]  sb_addr;
    logic [1:0]  rd_busy;
    logic [1:0]  rdBusyNb;

    int total = 0;
    int bad   = 0;

    reg_bank_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .NUM_WR(2),
                  .ZERO_REG(1), .BYPASS(1)) dut (
        .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
        .sb_set(sb_set), .sb_addr(sb_addr), .rd_busy(rd_busy)
    );

    reg_bank_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .NUM_WR(2),
                  .ZERO_REG(1), .BYPASS(0)) dutNb (
        .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rdDataNb),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
        .sb_set(sb_set), .sb_addr(sb_addr), .rd_busy(rdBusyNb)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [1:0]  en;
        logic [4:0]  a0;
        logic [31:0] d0;
        logic [3:0]  b0;
        logic [4:0]  a1;
        logic [31:0] d1;
        logic [3:0]  b1;
        logic [4:0]  r0;
        logic [4:0]  r1;
        logic [31:0] e0;    // bypass DUT, read port 0, before the edge
        logic [31:0] e1;    // bypass DUT, read port 1, before the edge
        logic [31:0] eOld;  // no-bypass DUT, read port 0, before the edge
    } vec_t;

    vec_t vecs [16];

    function automatic vec_t mk(
        input logic [1:0] en,
        input logic [4:0] a0, input logic [31:0] d0, input logic [3:0] b0,
        input logic [4:0] a1, input logic [31:0] d1, input logic [3:0] b1,
        input logic [4:0] r0, input logic [4:0] r1,
        input logic [31:0] e0, input logic [31:0] e1, input logic [31:0] eOld);
        vec_t v;
        v.en = en; v.a0 = a0; v.d0 = d0; v.b0 = b0;
        v.a1 = a1; v.d1 = d1; v.b1 = b1; v.r0 = r0; v.r1 = r1;
        v.e0 = e0; v.e1 = e1; v.eOld = eOld;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic idle();
        wr_en   = '0;
        wr_addr = '0;
        wr_data = '0;
        wr_be   = '0;
        sb_set  = 1'b0;
        sb_addr = '0;
    endtask

    initial begin
        // en, a0, d0, b0, a1, d1, b1, r0, r1, e0, e1, eOld
        vecs[0]  = mk(2'b01, 5'd1,  32'h0000000F, 4'hF, 5'd0, 32'h0,        4'h0, 5'd1,  5'd2,  32'h0000000F, 32'h00000000, 32'h00000000);
        vecs[1]  = mk(2'b00, 5'd0,  32'h0,        4'h0, 5'd0, 32'h0,        4'h0, 5'd1,  5'd1,  32'h0000000F, 32'h0000000F, 32'h0000000F);
        vecs[2]  = mk(2'b01, 5'd5,  32'h11223344, 4'hF, 5'd0, 32'h0,        4'h0, 5'd5,  5'd0,  32'h11223344, 32'h00000000, 32'h00000000);
        vecs[3]  = mk(2'b01, 5'd5,  32'hAABBCCDD, 4'h5, 5'd0, 32'h0,        4'h0, 5'd5,  5'd5,  32'h11BB33DD, 32'h11BB33DD, 32'h11223344);
        vecs[4]  = mk(2'b00, 5'd0,  32'h0,        4'h0, 5'd0, 32'h0,        4'h0, 5'd5,  5'd2,  32'h11BB33DD, 32'h00000000, 32'h11BB33DD);
        vecs[5]  = mk(2'b11, 5'd7,  32'h00000000, 4'hF, 5'd7, 32'hFFFFFFFF, 4'h3, 5'd7,  5'd7,  32'h0000FFFF, 32'h0000FFFF, 32'h00000000);
        vecs[6]  = mk(2'b00, 5'd0,  32'h0,        4'h0, 5'd0, 32'h0,        4'h0, 5'd7,  5'd5,  32'h0000FFFF, 32'h11BB33DD, 32'h0000FFFF);
        vecs[7]  = mk(2'b01, 5'd10, 32'h12345678, 4'hF, 5'd0, 32'h0,        4'h0, 5'd10, 5'd1,  32'h12345678, 32'h0000000F, 32'h00000000);
        vecs[8]  = mk(2'b11, 5'd0,  32'hDEADBEEF, 4'hF, 5'd0, 32'h01234567, 4'hF, 5'd0,  5'd10, 32'h00000000, 32'h12345678, 32'h00000000);
        vecs[9]  = mk(2'b00, 5'd0,  32'h0,        4'h0, 5'd0, 32'h0,        4'h0, 5'd0,  5'd0,  32'h00000000, 32'h00000000, 32'h00000000);
        vecs[10] = mk(2'b01, 5'd10, 32'hFFFFFFFF, 4'h0, 5'd0, 32'h0,        4'h0, 5'd10, 5'd10, 32'h12345678, 32'h12345678, 32'h12345678);
        vecs[11] = mk(2'b10, 5'd0,  32'h0,        4'h0, 5'd3, 32'hCAFEBABE, 4'hC, 5'd3,  5'd10, 32'hCAFE0000, 32'h12345678, 32'h00000000);
        vecs[12] = mk(2'b11, 5'd8,  32'h01010101, 4'hF, 5'd9, 32'h02020202, 4'hF, 5'd8,  5'd9,  32'h01010101, 32'h02020202, 32'h00000000);
        vecs[13] = mk(2'b00, 5'd0,  32'h0,        4'h0, 5'd0, 32'h0,        4'h0, 5'd8,  5'd3,  32'h01010101, 32'hCAFE0000, 32'h01010101);
        vecs[14] = mk(2'b10, 5'd9,  32'hFFFFFFFF, 4'hF, 5'd8, 32'hAAAAAAAA, 4'h1, 5'd9,  5'd8,  32'h02020202, 32'h010101AA, 32'h02020202);
        vecs[15] = mk(2'b00, 5'd0,  32'h0,        4'h0, 5'd0, 32'h0,        4'h0, 5'd9,  5'd8,  32'h02020202, 32'h010101AA, 32'h02020202);

        // Reset held across an edge: a concurrent write must be lost.
        rst = 1'b1;
        idle();
        wr_en   = 2'b01;
        wr_addr = {5'd0, 5'd1};
        wr_data = {32'h0, 32'hFFFFFFFF};
        wr_be   = 8'h0F;
        rd_addr = {5'd2, 5'd1};
        @(negedge clk);
        idle();
        rst = 1'b0;
        #1;
        check("reset_r1_lost", rd_data[31:0], 32'h0);
        check("reset_r2", rd_data[63:32], 32'h0);
        check("reset_busy", 32'(rd_busy), 32'h0);

        // Table: apply one cycle per vector, sample one time unit after driving.
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            wr_en   = vecs[i].en;
            wr_addr = {vecs[i].a1, vecs[i].a0};
            wr_data = {vecs[i].d1, vecs[i].d0};
            wr_be   = {vecs[i].b1, vecs[i].b0};
            rd_addr = {vecs[i].r1, vecs[i].r0};
            #1;
            check($sformatf("v%0d_p0", i), rd_data[31:0], vecs[i].e0);
            check($sformatf("v%0d_p1", i), rd_data[63:32], vecs[i].e1);
            check($sformatf("v%0d_nobyp", i), rdDataNb[31:0], vecs[i].eOld);
            check($sformatf("v%0d_busy", i), 32'(rd_busy), 32'h0);
        end
        @(negedge clk);
        idle();

`ifdef REG_BANK_SCOREBOARD_EN
        // Set R16 busy; visible only after the edge.
        sb_set  = 1'b1;
        sb_addr = 5'd16;
        rd_addr = {5'd17, 5'd16};
        #1;
        check("sb_pre_set", 32'(rd_busy[0]), 32'h0);
        @(negedge clk);
        idle();
        #1;
        check("sb_set16", 32'(rd_busy[0]), 32'h1);
        check("sb_set16_nb", 32'(rdBusyNb[0]), 32'h1);
        // Write one byte of R16: bypass hides busy now, storage clears at the edge.
        wr_en   = 2'b01;
        wr_addr = {5'd0, 5'd16};
        wr_data = {32'h0, 32'h000000AB};
        wr_be   = 8'h01;
        #1;
        check("sb_clr_byp", 32'(rd_busy[0]), 32'h0);
        check("sb_clr_nobyp", 32'(rdBusyNb[0]), 32'h1);
        @(negedge clk);
        idle();
        #1;
        check("sb_clr16", 32'(rd_busy[0]), 32'h0);
        check("sb_clr16_nb", 32'(rdBusyNb[0]), 32'h0);
        // Set and clear R17 in the same cycle: set wins.
        sb_set  = 1'b1;
        sb_addr = 5'd17;
        wr_en   = 2'b01;
        wr_addr = {5'd0, 5'd17};
        wr_data = {32'h0, 32'h55555555};
        wr_be   = 8'h0F;
        @(negedge clk);
        idle();
        #1;
        check("sb_setwins", 32'(rd_busy[1]), 32'h1);
        // An enabled write with no byte lanes does not clear busy.
        wr_en   = 2'b01;
        wr_addr = {5'd0, 5'd17};
        wr_be   = 8'h00;
        #1;
        check("sb_be0_byp", 32'(rd_busy[1]), 32'h1);
        @(negedge clk);
        idle();
        #1;
        check("sb_be0_hold", 32'(rd_busy[1]), 32'h1);
        // sb_set to register 0 is ignored.
        sb_set  = 1'b1;
        sb_addr = 5'd0;
        rd_addr = {5'd17, 5'd0};
        @(negedge clk);
        idle();
        #1;
        check("sb_zero", 32'(rd_busy[0]), 32'h0);
`else
        // Without the scoreboard rd_busy stays low whatever sb_set does.
        sb_set  = 1'b1;
        sb_addr = 5'd16;
        rd_addr = {5'd17, 5'd16};
        @(negedge clk);
        idle();
        #1;
        check("sb_absent", 32'(rd_busy), 32'h0);
        check("sb_absent_nb", 32'(rdBusyNb), 32'h0);
`endif

        // Asynchronous reset mid-cycle: R1 clears before the next edge.
        @(negedge clk);
        idle();
        rd_addr = {5'd17, 5'd1};
        #1;
        check("pre_rst_r1", rd_data[31:0], 32'h0000000F);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_r1", rd_data[31:0], 32'h0);
        check("async_rst_r17", rd_data[63:32], 32'h0);
        check("async_rst_nb", rdDataNb[31:0], 32'h0);
        check("async_rst_busy", 32'(rd_busy), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("post_rst_r1", rd_data[31:0], 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
